uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that sits directly downstream of the priRV32 core top and turns byte writes from the core into a serial line. It accepts bytes on a valid/ready handshake into a small FIFO. It serialises them at a fixed baud rate derived from the system clock. Consecutive bytes go out back-to-back with no idle gap.

---
 rtl/uart_tx_fifo.sv | 145 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes enter a small FIFO over a valid/ready
// handshake and are serialised LSB first, back-to-back, at a fixed baud rate.
module uart_tx_fifo #(
    parameter int CLK_MHZ = 50,
    parameter int BAUD    = 115200,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int DIV = (CLK_MHZ * 1_000_000) / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_fifo: clock/baud ratio must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    shift, shift_next;
    logic [2:0]    bit_idx, bit_next;
    logic [BW-1:0] baud_cnt, baud_next;
    logic          tx_next;
    logic          push, pop, baud_done;

    assign tx_ready   = (count != FULL);
    assign push       = tx_valid && tx_ready;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);
    assign baud_done  = (baud_cnt == BAUD_LAST);

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        state_next = state;
        shift_next = shift;
        bit_next   = bit_idx;
        baud_next  = baud_cnt;
        pop        = 1'b0;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_done) begin
                    baud_next = '0;
                    // Popping here chains the next start bit with no idle gap.
                    if (count != '0) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            bit_idx  <= bit_next;
            baud_cnt <= baud_next;
            tx       <= tx_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-position reference model is
// compared every cycle, with hand-computed literal checks on directed scenarios.
module tb_uart_tx_fifo;
    localparam int CLK_MHZ = 1;
    localparam int BAUD    = 250000;
    localparam int DEPTH   = 4;
    localparam int DIV     = (CLK_MHZ * 1_000_000) / BAUD;
    localparam int FRAME   = 10 * DIV;
    localparam int LW      = 13;
    localparam int LOG_LEN = 1 << LW;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx, busy;
    logic [$clog2(DEPTH):0] fifo_count;

    uart_tx_fifo #(.CLK_MHZ(CLK_MHZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx(tx),
        .busy(busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   check_en = 1'b0;
    logic log_mem [LOG_LEN];

    // Reference model: a byte queue plus the position inside the frame on air.
    logic [7:0] m_q [$];
    logic [7:0] m_cur = 8'h00;
    int         m_pos = -1;
    logic       m_tx = 1'b1;
    bit         m_can_push;

    logic [7:0] full_exp [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hE1};
    logic [9:0] a5_line = 10'b11_0100_1010;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    function automatic logic line_level(input logic [7:0] b, input int pos);
        int slot;
        slot = pos / DIV;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[3'(slot - 1)];
    endfunction

    function automatic logic logAt(input int idx);
        if (idx < 0 || idx >= LOG_LEN) return 1'bx;
        return log_mem[LW'(idx)];
    endfunction

    function automatic logic [7:0] decodeAt(input int start);
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            r[b] = logAt(start + DIV * (b + 1) + DIV / 2);
        end
        return r;
    endfunction

    task automatic checkFrame(input string name, input int start, input logic [7:0] expected);
        checkOutput({name, "_start"}, 32'(logAt(start)), 0);
        checkOutput(name, 32'(decodeAt(start)), 32'(expected));
        checkOutput({name, "_stop"}, 32'(logAt(start + 9 * DIV + DIV / 2)), 1);
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        tx_valid = v;
        tx_data  = d;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput(name, 32'(busy), 0);
    endtask

    // Model update on every rising edge, using the inputs the DUT sees.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst_n) begin
                m_q.delete();
                m_pos = -1;
                m_tx  = 1'b1;
            end else begin
                m_can_push = (m_q.size() < DEPTH);
                m_tx = (m_pos < 0) ? 1'b1 : line_level(m_cur, m_pos);
                if (m_pos < 0 || m_pos == FRAME - 1) begin
                    if (m_q.size() > 0) begin
                        m_cur = m_q.pop_front();
                        m_pos = 0;
                    end else begin
                        m_pos = -1;
                    end
                end else begin
                    m_pos = m_pos + 1;
                end
                if (tx_valid && m_can_push) m_q.push_back(tx_data);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc < LOG_LEN) log_mem[LW'(cyc)] = tx;
            if (check_en) begin
                checkOutput("tx", 32'(tx), 32'(m_tx));
                checkOutput("tx_ready", 32'(tx_ready), 32'(m_q.size() < DEPTH));
                checkOutput("busy", 32'(busy), 32'(m_pos >= 0 || m_q.size() > 0));
                checkOutput("fifo_count", 32'(fifo_count), 32'(m_q.size()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;
        checkOutput("reset_tx", 32'(tx), 1);
        checkOutput("reset_ready", 32'(tx_ready), 1);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_count", 32'(fifo_count), 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 8'h00);
            checkOutput("idle_tx", 32'(tx), 1);
            checkOutput("idle_busy", 32'(busy), 0);
        end

        // Single byte: latency, exact line levels, busy release.
        applyStimulus(1'b1, 8'hA5);
        checkOutput("lat_count_n", 32'(fifo_count), 1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("lat_count_n1", 32'(fifo_count), 0);
        checkOutput("lat_tx_n1", 32'(tx), 1);
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b0, 8'h00);
            checkOutput("a5_line", 32'(tx), 32'(a5_line[4'(i / DIV)]));
            if (i == FRAME - 2) checkOutput("a5_busy_stop", 32'(busy), 1);
        end
        checkOutput("a5_busy_end", 32'(busy), 0);

        // Three bytes back-to-back.
        base = cyc + 1;
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b1, 8'h55);
        checkOutput("b2b_count", 32'(fifo_count), 2);
        checkOutput("b2b_start0", 32'(tx), 0);
        idleCycles(FRAME - 1);
        checkOutput("b2b_stop0", 32'(tx), 1);
        idleCycles(1);
        checkOutput("b2b_start1", 32'(tx), 0);
        idleCycles(FRAME - 1);
        checkOutput("b2b_stop1", 32'(tx), 1);
        idleCycles(1);
        checkOutput("b2b_start2", 32'(tx), 0);
        waitIdle("b2b_drain", 2 * FRAME);
        checkFrame("b2b_byte0", base + 2, 8'h00);
        checkFrame("b2b_byte1", base + 2 + FRAME, 8'hFF);
        checkFrame("b2b_byte2", base + 2 + 2 * FRAME, 8'h55);

        // Saturate the FIFO, then push on the same edge as the stop-end pop.
        base = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(i));
            if (i == 3) checkOutput("fill_ready_3", 32'(tx_ready), 1);
            if (i == 4) begin
                checkOutput("fill_ready_4", 32'(tx_ready), 0);
                checkOutput("fill_count_4", 32'(fifo_count), 4);
            end
        end
        checkOutput("fill_count_hold", 32'(fifo_count), 4);
        idleCycles(FRAME - 9);
        checkOutput("pre_pop_ready", 32'(tx_ready), 0);
        applyStimulus(1'b1, 8'hE1);
        checkOutput("pop_edge_count", 32'(fifo_count), 3);
        checkOutput("pop_edge_ready", 32'(tx_ready), 1);
        applyStimulus(1'b1, 8'hE1);
        checkOutput("refill_count", 32'(fifo_count), 4);
        checkOutput("refill_ready", 32'(tx_ready), 0);
        waitIdle("fill_drain", 6 * FRAME + 20);
        foreach (full_exp[k]) checkFrame("fill_byte", base + 2 + FRAME * k, full_exp[k]);

        // Reset during data bit 3 of 0x3C with another byte queued.
        base = cyc + 1;
        applyStimulus(1'b1, 8'h3C);
        applyStimulus(1'b1, 8'h77);
        idleCycles(17);
        checkOutput("pre_reset_count", 32'(fifo_count), 1);
        checkOutput("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00);
        rst_n = 1'b1;
        checkOutput("mid_reset_tx", 32'(tx), 1);
        checkOutput("mid_reset_count", 32'(fifo_count), 0);
        checkOutput("mid_reset_busy", 32'(busy), 0);
        checkOutput("mid_reset_ready", 32'(tx_ready), 1);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0, 8'h00);
            checkOutput("post_reset_tx", 32'(tx), 1);
        end
        base = cyc + 1;
        applyStimulus(1'b1, 8'h81);
        waitIdle("fresh_drain", FRAME + 10);
        checkFrame("fresh_byte", base + 2, 8'h81);

        // Random traffic at three densities with rare resets.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            if (i < 400)      applyStimulus(($urandom_range(0, 1) == 0), 8'($urandom));
            else if (i < 800) applyStimulus(($urandom_range(0, 59) == 0), 8'($urandom));
            else              applyStimulus(($urandom_range(0, 29) == 0), 8'($urandom));
            rst_n = 1'b1;
        end
        waitIdle("rand_drain", FRAME * (DEPTH + 2));

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
